shift_sequencer: RTL and testbench

Multi-cycle shift unit controller for area-reduced configurations of the core. It applies SLL, SRL and SRA using one log-step stage per cycle (power-of-two amounts 1, 2, 4, ... 2**(nb_bits_shift-1)). This replaces the fully unrolled combinational barrel shifter. It sits between the ALU issue logic and the writeback mux and uses a start/ready/done handshake.

---
 rtl/shift_sequencer.sv | 172 +++++++++++++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Multi-cycle SLL / SRL / SRA unit. The operand is shifted by one
//             power-of-two stage per cycle (1, 2, 4, ... 2**(NB_BITS_SHIFT-1)),
//             so a single stage of shift logic replaces a full barrel shifter.
//             Latency is fixed at NB_BITS_SHIFT stage cycles plus one DONE
//             cycle, whatever the amount or op.
//  Ports    : clk_i          - clock, rising-edge
//             rst_i          - synchronous active-high reset
//             start_i        - request valid, accepted only while ready_o=1
//             op_i           - 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//             data_i         - operand, sampled at accept
//             shift_value_i  - shift amount, sampled at accept
//             ready_o        - a request can be accepted this cycle
//             busy_o         - operation in progress
//             done_o         - one-cycle pulse, data_o is valid
//             data_o         - result, held until the next DONE
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int NB_BITS_DATA  = 32,
    parameter int NB_BITS_SHIFT = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [1:0]               op_i,
    input  logic [NB_BITS_DATA-1:0]  data_i,
    input  logic [NB_BITS_SHIFT-1:0] shift_value_i,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [NB_BITS_DATA-1:0]  data_o
);

    // Stage counter is one bit wider than needed to index the amount so the
    // terminal value never aliases back to zero.
    localparam int CNT_W = $clog2(NB_BITS_SHIFT) + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NB_BITS_SHIFT - 1);
    localparam logic [1:0]       c_op_sll   = 2'b00;
    localparam logic [1:0]       c_op_srl   = 2'b01;
    localparam logic [1:0]       c_op_sra   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                                     r_state;
    state_t                                     w_state_next;
    logic [CNT_W-1:0]                           r_cnt;
    logic [NB_BITS_DATA-1:0]                    r_work;
    logic [NB_BITS_SHIFT-1:0]                   r_amt;
    logic [1:0]                                 r_op;
    logic [NB_BITS_DATA-1:0]                    r_data_out;

    logic                                       w_ready;
    logic                                       w_accept;
    logic                                       w_last_stage;
    logic [NB_BITS_DATA-1:0]                    w_work_next;
    logic [NB_BITS_SHIFT-1:0][NB_BITS_DATA-1:0] w_stage_res;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_ready      = (r_state != ST_SHIFT);
    assign w_accept     = start_i && w_ready;
    assign w_last_stage = (r_state == ST_SHIFT) && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // Fixed-distance stage results. Each entry is the working register
    // shifted by the constant 2**j; only the entry matching the current
    // counter value is ever committed. SRA takes the sign from the current
    // working MSB so it propagates correctly through successive stages.
    // The reserved op leaves the operand untouched.
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NB_BITS_SHIFT; j++) begin : g_stage
        localparam int c_step = 2 ** j;

        assign w_stage_res[j] =
            (r_op == c_op_sll) ? (r_work << c_step) :
            (r_op == c_op_srl) ? (r_work >> c_step) :
            (r_op == c_op_sra) ? NB_BITS_DATA'($signed(r_work) >>> c_step) :
                                 r_work;
    end

    // Stage k applies its shift only when amount bit k is set.
    always_comb begin
        w_work_next = r_work;
        for (int j = 0; j < NB_BITS_SHIFT; j++) begin
            if ((r_cnt == CNT_W'(j)) && r_amt[j]) begin
                w_work_next = w_stage_res[j];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // DONE lasts one cycle; a request here is issued back-to-back.
                w_state_next = start_i ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_work     <= '0;
            r_amt      <= '0;
            r_op       <= '0;
            r_data_out <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_work <= data_i;
            r_amt  <= shift_value_i;
            r_op   <= op_i;
        end else if (r_state == ST_SHIFT) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_work <= w_work_next;
            // Result register only changes on entry to DONE, so data_o keeps
            // the previous result during IDLE and the following SHIFT.
            if (w_last_stage) begin
                r_data_out <= w_work_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_o = w_ready;
    assign busy_o  = (r_state == ST_SHIFT);
    assign done_o  = (r_state == ST_DONE);
    assign data_o  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Purpose  : Self-checking bench for shift_sequencer. Vector table of
//             {op, data, amount, expected result}, a result scoreboard queue
//             drained on every done_o pulse, and hand-written sequences for
//             ignored starts, back-to-back issue and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int NB_BITS_DATA  = 32;
    localparam int NB_BITS_SHIFT = 5;

    logic                     clk;
    logic                     rst;
    logic                     start_i;
    logic [1:0]               op_i;
    logic [NB_BITS_DATA-1:0]  data_i;
    logic [NB_BITS_SHIFT-1:0] shift_value_i;
    logic                     ready_o;
    logic                     busy_o;
    logic                     done_o;
    logic [NB_BITS_DATA-1:0]  data_o;

    shift_sequencer #(
        .NB_BITS_DATA  (NB_BITS_DATA),
        .NB_BITS_SHIFT (NB_BITS_SHIFT)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .data_i        (data_i),
        .shift_value_i (shift_value_i),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .data_o        (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt[14];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Scoreboard: every done_o pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", data_o, sb_q.pop_front());
            end
        end
    end

    // Waits for ready_o, drives one request for one edge, optionally records
    // its expected result. Returns with time at #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] a, input bit push, input logic [31:0] exp);
        int w = 0;
        while (ready_o !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) check("ready_timeout", 32'(ready_o), 32'd1);
        start_i       = 1'b1;
        op_i          = op;
        data_i        = d;
        shift_value_i = a;
        if (push) sb_q.push_back(exp);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Counts edges after the accept edge until done_o is seen.
    task automatic wait_done(output int cyc, output int low_cnt);
        cyc     = 0;
        low_cnt = (ready_o === 1'b0) ? 1 : 0;
        while (cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (done_o === 1'b1) break;
            if (ready_o === 1'b0) low_cnt++;
        end
    endtask

    initial begin
        int cyc, low_cnt, d0;

        vt[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vt[1]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vt[2]  = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vt[3]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vt[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vt[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vt[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vt[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF};
        vt[8]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vt[9]  = '{2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800};
        vt[10] = '{2'b01, 32'h1234_5678, 5'd12, 32'h0001_2345};
        vt[11] = '{2'b10, 32'hF000_0000, 5'd3,  32'hFE00_0000};
        vt[12] = '{2'b00, 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000};
        vt[13] = '{2'b10, 32'h8000_0001, 5'd1,  32'hC000_0000};

        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; data_i = '0; shift_value_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_busy",  32'(busy_o),  32'd0);
        check("reset_done",  32'(done_o),  32'd0);
        check("reset_data",  data_o,       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors with latency and ready-low checks.
        for (int i = 0; i < 14; i++) begin
            issue(vt[i].op, vt[i].data, vt[i].amt, 1'b1, vt[i].exp);
            check("busy_after_accept", 32'(busy_o), 32'd1);
            wait_done(cyc, low_cnt);
            check("latency", 32'(cyc), 32'd5);
            check("ready_low_cycles", 32'(low_cnt), 32'd5);
            @(posedge clk); #1;
            check("hold_in_idle", data_o, vt[i].exp);
        end

        // start_i held high with different data while SHIFT is in progress.
        issue(2'b00, 32'h0000_0003, 5'd1, 1'b1, 32'h0000_0006);
        d0 = n_done;
        start_i = 1'b1; op_i = 2'b10; data_i = 32'hFFFF_FFFF; shift_value_i = 5'd5;
        repeat (3) begin @(posedge clk); #1; end
        start_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("ignored_start_done_count", 32'(n_done - d0), 32'd1);

        // Back-to-back: second request issued in the DONE cycle.
        issue(2'b01, 32'h0000_00F0, 5'd4, 1'b1, 32'h0000_000F);
        wait_done(cyc, low_cnt);
        check("b2b_first_latency", 32'(cyc), 32'd5);
        issue(2'b00, 32'h0000_000F, 5'd4, 1'b1, 32'h0000_00F0);
        check("b2b_done_dropped", 32'(done_o), 32'd0);
        check("b2b_busy", 32'(busy_o), 32'd1);
        check("b2b_first_held", data_o, 32'h0000_000F);
        wait_done(cyc, low_cnt);
        check("b2b_second_spacing", 32'(cyc + 1), 32'd6);
        check("b2b_second_data", data_o, 32'h0000_00F0);
        @(posedge clk); #1;

        // Reset in the third SHIFT cycle aborts the request.
        issue(2'b10, 32'h8000_0000, 5'd31, 1'b0, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        check("pre_abort_busy", 32'(busy_o), 32'd1);
        d0 = n_done;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_busy",  32'(busy_o),  32'd0);
        check("abort_done",  32'(done_o),  32'd0);
        check("abort_data",  data_o,       32'd0);
        repeat (8) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(n_done - d0), 32'd0);

        issue(2'b00, 32'h0000_000F, 5'd4, 1'b1, 32'h0000_00F0);
        wait_done(cyc, low_cnt);
        check("post_abort_latency", 32'(cyc), 32'd5);
        check("post_abort_data", data_o, 32'h0000_00F0);
        repeat (2) begin @(posedge clk); #1; end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
